// File: rtl/key_sched_seq.sv
// key_sched_seq: AES key-expansion word sequencer.
// Steps the word index i from Nk to Last for AES-128/192/256. It tracks
// i mod Nk and i / Nk with counters, so no divider is needed, and it decodes
// the RotWord/SubWord flags for the word datapath.
module key_sched_seq #(
    parameter int IDX_W  = 6,   // must satisfy 2^IDX_W  >= 60
    parameter int RCON_W = 4    // must satisfy 2^RCON_W >= 11
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic              En,
    output logic [IDX_W-1:0]  word_idx,
    output logic [3:0]        phase,
    output logic [RCON_W-1:0] rcon_idx,
    output logic              rot_sub,
    output logic              sub_only,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        nk_q, nk_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        phase_q, phase_d;
    logic [RCON_W-1:0] rcon_q, rcon_d;

    logic [3:0]        nk_sel;
    logic [IDX_W-1:0]  last;

    // Decode the requested key size. The unused code 11 falls back to AES-128.
    always_comb begin
        nk_sel = 4'd4;
        case (Mode)
            2'b01:   nk_sel = 4'd6;
            2'b10:   nk_sel = 4'd8;
            default: nk_sel = 4'd4;
        endcase
    end

    // Final word index, taken from the latched Nk only.
    // Mode is not used here, so it cannot alter a run in flight.
    always_comb begin
        last = IDX_W'(43);
        case (nk_q)
            4'd6:    last = IDX_W'(51);
            4'd8:    last = IDX_W'(59);
            default: last = IDX_W'(43);
        endcase
    end

    // State and index registers. Reset puts the block back to its power-on values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            nk_q    <= 4'd4;
            idx_q   <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
        end
    end

    // Next-state logic. The phase counter wraps at Nk-1 and carries into the
    // round-constant index, which gives i mod Nk and i / Nk incrementally.
    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    nk_d    = nk_sel;
                    idx_d   = IDX_W'(nk_sel);
                    phase_d = 4'd0;
                    rcon_d  = RCON_W'(1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (En) begin
                    if (idx_q == last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (phase_q == nk_q - 4'd1) begin
                            phase_d = 4'd0;
                            rcon_d  = rcon_q + RCON_W'(1);
                        end else begin
                            phase_d = phase_q + 4'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    // There is no path from any input to any output.
    always_comb begin
        word_idx = idx_q;
        phase    = phase_q;
        rcon_idx = rcon_q;
        Busy     = (state_q == S_RUN);
        Done     = (state_q == S_DONE);
        rot_sub  = Busy && (phase_q == 4'd0);
        sub_only = Busy && (nk_q == 4'd8) && (phase_q == 4'd4);
    end

endmodule

// File: tb/tb_key_sched_seq.sv
// Scoreboard bench for key_sched_seq. The stimulus pushes the expected
// word-by-word outputs into a queue. The monitor pops one entry on every
// Busy or Done cycle and compares it against the DUT outputs.
module tb_key_sched_seq;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic       En = 1'b0;
    logic [5:0] word_idx;
    logic [3:0] phase;
    logic [3:0] rcon_idx;
    logic       rot_sub, sub_only, Busy, Done;

    key_sched_seq #(.IDX_W(6), .RCON_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .En(En),
        .word_idx(word_idx), .phase(phase), .rcon_idx(rcon_idx),
        .rot_sub(rot_sub), .sub_only(sub_only), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int idx;
        int ph;
        int rc;
        bit rot;
        bit sub;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_cnt = 0, rot_cnt = 0, sub_cnt = 0, done_cnt = 0;
    int   exp_idle_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge Clk) begin
        if (!Rst) begin
            chk("rot_sub_and_sub_only_exclusive", 32'(rot_sub & sub_only), 0);
            if (Busy) busy_cnt++;
            if (rot_sub) rot_cnt++;
            if (sub_only) sub_cnt++;
            if (Done) done_cnt++;
            if (Busy || Done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy_or_done", 32'({Busy, Done}), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_idx", 32'(word_idx), e.idx);
                    chk("phase", 32'(phase), e.ph);
                    chk("rcon_idx", 32'(rcon_idx), e.rc);
                    chk("rot_sub", 32'(rot_sub), 32'(e.rot));
                    chk("sub_only", 32'(sub_only), 32'(e.sub));
                    chk("busy", 32'(Busy), 32'(!e.done));
                    chk("done", 32'(Done), 32'(e.done));
                end
            end else begin
                chk("idle_word_idx_hold", 32'(word_idx), exp_idle_idx);
                chk("idle_flags", 32'({rot_sub, sub_only}), 0);
            end
        end
    end

    // Push the expected entries for word indices nk..upto. The entry for
    // stall_k is repeated stall_n extra times.
    task automatic push_run(input int nk, input int upto, input int stall_k, input int stall_n);
        exp_t e;
        for (int i = nk; i <= upto; i++) begin
            e.idx  = i;
            e.ph   = i % nk;
            e.rc   = i / nk;
            e.rot  = (i % nk) == 0;
            e.sub  = (nk == 8) && ((i % nk) == 4);
            e.done = 1'b0;
            for (int r = 0; r <= ((i - nk == stall_k) ? stall_n : 0); r++) exp_q.push_back(e);
        end
    endtask

    task automatic clr_counts();
        busy_cnt = 0; rot_cnt = 0; sub_cnt = 0; done_cnt = 0;
    endtask

    // Complete run. With abuse set, Start pulses and Mode toggles between 00
    // and 10 throughout RUN and DONE.
    task automatic run(input logic [1:0] mode, input int nk, input int stall_k, input int stall_n,
                       input bit abuse, input int exp_busy, input int exp_rot, input int exp_sub,
                       input int exp_rc);
        int   last;
        int   total;
        exp_t e;
        last = 4 * (nk + 7) - 1;
        push_run(nk, last, stall_k, stall_n);
        e.idx = last; e.ph = last % nk; e.rc = last / nk; e.rot = 0; e.sub = 0; e.done = 1;
        exp_q.push_back(e);
        clr_counts();
        Start = 1; Mode = mode; En = 1;
        @(posedge Clk); #1;
        Start = 0;
        exp_idle_idx = last;
        total = last - nk + 1 + stall_n;
        for (int c = 0; c < total; c++) begin
            En = (c >= stall_k && c < stall_k + stall_n) ? 1'b0 : 1'b1;
            if (abuse) begin
                Start = c[0];
                Mode  = c[0] ? 2'b10 : 2'b00;
            end
            @(posedge Clk); #1;
        end
        En = 1;
        if (abuse) begin
            Start = 1; Mode = 2'b10;
        end
        @(posedge Clk); #1;
        Start = 0; Mode = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("rot_sub_count", rot_cnt, exp_rot);
        chk("sub_only_count", sub_cnt, exp_sub);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_rcon_idx", 32'(rcon_idx), exp_rc);
        chk("final_word_idx", 32'(word_idx), last);
    endtask

    initial begin
        #2;
        chk("rst_word_idx", 32'(word_idx), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_rcon_idx", 32'(rcon_idx), 0);
        chk("rst_flags", 32'({rot_sub, sub_only, Busy, Done}), 0);
        #10 Rst = 0;
        @(posedge Clk); #1;

        run(2'b00, 4, -1, 0, 0, 40, 10, 0, 10);   // AES-128
        run(2'b01, 6, -1, 0, 0, 46, 8, 0, 8);     // AES-192
        run(2'b10, 8, -1, 0, 0, 52, 7, 6, 7);     // AES-256
        run(2'b00, 4, 3, 3, 0, 43, 10, 0, 10);    // stall 3 cycles at i=7
        run(2'b00, 4, -1, 0, 1, 40, 10, 0, 10);   // Start/Mode abuse
        run(2'b11, 4, -1, 0, 0, 40, 10, 0, 10);   // Mode 11 acts as AES-128

        // Reset mid-run at i=30 of an AES-256 run
        push_run(8, 30, -1, 0);
        clr_counts();
        Start = 1; Mode = 2'b10; En = 1;
        @(posedge Clk); #1;
        Start = 0;
        exp_idle_idx = 59;
        for (int c = 0; c < 22; c++) begin
            @(posedge Clk); #1;
        end
        #6 Rst = 1;
        #1;
        chk("midrst_word_idx", 32'(word_idx), 0);
        chk("midrst_phase", 32'(phase), 0);
        chk("midrst_rcon_idx", 32'(rcon_idx), 0);
        chk("midrst_flags", 32'({rot_sub, sub_only, Busy, Done}), 0);
        chk("midrst_queue_drained", exp_q.size(), 0);
        exp_idle_idx = 0;
        @(posedge Clk); #3;
        Rst = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("midrst_no_done", done_cnt, 0);
        run(2'b10, 8, -1, 0, 0, 52, 7, 6, 7);     // normal run after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
